// File: rtl/train_gate_sequencer.sv
// Train gate sequencer: synchronizes and debounces two track sensors,
// detects travel direction and produces the measure_en timing gate with
// done/timeout completion pulses.
module train_gate_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic measure_en,
    output logic done,
    output logic timeout,
    output logic dir,
    output logic busy
);

    typedef enum logic [1:0] {
        SETTLE,
        IDLE,
        MEASURE,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    // bit 0 = sensor A, bit 1 = sensor B
    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_prev_q;
    logic [CNT_W-1:0] dcnt_q [2];
    logic [1:0]       rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             measure_en_q;

    assign raw  = {sensor_b, sensor_a};
    assign rise = deb_q & ~deb_prev_q;

    // Two-flop synchronizer for both raw sensors.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: flip the accepted level after DEBOUNCE_CYCLES disagreeing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            deb_prev_q <= deb_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (dcnt_q[i] == DEB_LAST) begin
                        deb_q[i]  <= sync2_q[i];
                        dcnt_q[i] <= '0;
                    end else begin
                        dcnt_q[i] <= dcnt_q[i] + 1'b1;
                    end
                end else begin
                    dcnt_q[i] <= '0;
                end
            end
        end
    end

    // Next-state and pulse decode; one counter serves both SETTLE and MEASURE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = HOLD;
                end
            end
            IDLE: begin
                if (rise[0] && !rise[1]) begin
                    state_d = MEASURE;
                    dir_d   = 1'b0;
                    cnt_d   = '0;
                end else if (rise[1] && !rise[0]) begin
                    state_d = MEASURE;
                    dir_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + 1'b1;
                // A rise on the far sensor takes priority over the timeout.
                if (dir_q ? rise[0] : rise[1]) begin
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SETTLE;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            measure_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            measure_en_q <= (state_d == MEASURE);
        end
    end

    assign measure_en = measure_en_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign dir        = dir_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_train_gate_sequencer.sv
// Bench for train_gate_sequencer: scenario tasks with randomized timing,
// expectations computed from the latency/width rules of the gate.
module tb_train_gate_sequencer;

    localparam int D = 4;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst;
    logic sensor_a;
    logic sensor_b;
    logic measure_en;
    logic done;
    logic timeout;
    logic dir;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor state (written only by the monitor process)
    int   edge_n     = 0;
    int   n_rise     = 0;
    int   n_done     = 0;
    int   n_tmo      = 0;
    int   n_bad      = 0;
    int   rise_edge  = 0;
    int   fall_edge  = 0;
    logic prev_me    = 1'b0;
    logic prev_done  = 1'b0;
    logic prev_tmo   = 1'b0;

    train_gate_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .measure_en(measure_en),
        .done      (done),
        .timeout   (timeout),
        .dir       (dir),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Edge counter and gate/pulse event recorder, sampled 1 unit after each edge.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        if (measure_en === 1'b1 && prev_me !== 1'b1) begin
            n_rise    = n_rise + 1;
            rise_edge = edge_n;
        end
        if (measure_en !== 1'b1 && prev_me === 1'b1) fall_edge = edge_n;
        if (done === 1'b1) n_done = n_done + 1;
        if (timeout === 1'b1) n_tmo = n_tmo + 1;
        if (done === 1'b1 && timeout === 1'b1) n_bad = n_bad + 1;
        if ((done === 1'b1 || timeout === 1'b1) && !(prev_me === 1'b1 && measure_en !== 1'b1))
            n_bad = n_bad + 1;
        if ((done === 1'b1 && prev_done === 1'b1) || (timeout === 1'b1 && prev_tmo === 1'b1))
            n_bad = n_bad + 1;
        prev_me   = measure_en;
        prev_done = done;
        prev_tmo  = timeout;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Return so that the next input change is first sampled at edge k.
    task automatic at_edge(input int k);
        while (edge_n < k - 1) step(1);
    endtask

    // Drive one train: first sensor now, second after 'interval' edges, both
    // released later. Model: gate rises D+2 edges after first sample, width is
    // the interval if it is <= T (done), otherwise T (timeout).
    task automatic run_transit(input bit b_first, input int interval, input string name);
        int kA, kR, exp_w, exp_done, exp_tmo;
        int b_rise, b_done, b_tmo, b_bad;
        b_rise = n_rise; b_done = n_done; b_tmo = n_tmo; b_bad = n_bad;
        kA = edge_n + 1;
        if (b_first) sensor_b = 1'b1; else sensor_a = 1'b1;
        at_edge(kA + interval);
        if (b_first) sensor_a = 1'b1; else sensor_b = 1'b1;
        kR = kA + interval + D + 5;
        at_edge(kR);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        at_edge(kR + D + 2);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_before_idle: got %b expected 1", name, busy);
        end
        step(1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after_release: got %b expected 0", name, busy);
        end
        exp_w    = (interval <= T) ? interval : T;
        exp_done = (interval <= T) ? 1 : 0;
        exp_tmo  = 1 - exp_done;
        vectors++;
        if (n_rise - b_rise !== 1) begin
            miscompares++;
            $display("FAIL %s gate_starts: got %0d expected 1", name, n_rise - b_rise);
        end
        vectors++;
        if (rise_edge !== kA + D + 2) begin
            miscompares++;
            $display("FAIL %s gate_rise_edge: got %0d expected %0d", name, rise_edge, kA + D + 2);
        end
        vectors++;
        if (fall_edge - rise_edge !== exp_w) begin
            miscompares++;
            $display("FAIL %s gate_width: got %0d expected %0d", name, fall_edge - rise_edge, exp_w);
        end
        vectors++;
        if (n_done - b_done !== exp_done) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d expected %0d", name, n_done - b_done, exp_done);
        end
        vectors++;
        if (n_tmo - b_tmo !== exp_tmo) begin
            miscompares++;
            $display("FAIL %s timeout_pulses: got %0d expected %0d", name, n_tmo - b_tmo, exp_tmo);
        end
        vectors++;
        if (dir !== b_first) begin
            miscompares++;
            $display("FAIL %s dir: got %b expected %b", name, dir, b_first);
        end
        vectors++;
        if (n_bad - b_bad !== 0) begin
            miscompares++;
            $display("FAIL %s pulse_shape: got %0d bad pulses expected 0", name, n_bad - b_bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        step(3);
        vectors++;
        if ({measure_en, done, timeout, dir} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0000", {measure_en, done, timeout, dir});
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
        step(D + 5);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_reach_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_a_to_b();
        run_transit(1'b0, 50, "a_to_b");
    endtask

    task automatic test_b_to_a();
        run_transit(1'b1, 25, "b_to_a");
    endtask

    task automatic test_glitch();
        int kP, b_rise, b_done;
        b_rise = n_rise; b_done = n_done;
        sensor_a = 1'b1;
        step(3);
        sensor_a = 1'b0;
        step(2);
        kP = edge_n + 1;
        sensor_a = 1'b1;
        step(6);
        sensor_a = 1'b0;
        at_edge(kP + 30);
        sensor_b = 1'b1;
        at_edge(kP + 30 + D + 5);
        sensor_b = 1'b0;
        step(D + 4);
        vectors++;
        if (n_rise - b_rise !== 1) begin
            miscompares++;
            $display("FAIL glitch_starts: got %0d expected 1", n_rise - b_rise);
        end
        vectors++;
        if (rise_edge !== kP + D + 2) begin
            miscompares++;
            $display("FAIL glitch_rise_edge: got %0d expected %0d", rise_edge, kP + D + 2);
        end
        vectors++;
        if (fall_edge - rise_edge !== 30 || n_done - b_done !== 1) begin
            miscompares++;
            $display("FAIL glitch_pulse_measure: got width %0d done %0d expected 30 1",
                     fall_edge - rise_edge, n_done - b_done);
        end
    endtask

    task automatic test_timeout();
        run_transit(1'b0, T + 25, "timeout_hold_b");
        run_transit(1'b0, 37, "after_timeout");
    endtask

    task automatic test_reset_mid();
        int kA, b_rise, b_done, b_tmo;
        b_rise = n_rise; b_done = n_done; b_tmo = n_tmo;
        kA = edge_n + 1;
        sensor_a = 1'b1;
        at_edge(kA + D + 2 + 10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        vectors++;
        if ({measure_en, done, timeout, busy} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_after_edge: got me,dn,to,busy=%b expected 0001",
                     {measure_en, done, timeout, busy});
        end
        step(40);
        vectors++;
        if (n_rise - b_rise !== 1 || measure_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_no_restart: got starts %0d me %b expected 1 0",
                     n_rise - b_rise, measure_en);
        end
        vectors++;
        if (n_done - b_done !== 0 || n_tmo - b_tmo !== 0) begin
            miscompares++;
            $display("FAIL rstmid_no_pulse: got done %0d timeout %0d expected 0 0",
                     n_done - b_done, n_tmo - b_tmo);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy_held: got %b expected 1", busy);
        end
        sensor_a = 1'b0;
        step(D + 4);
        run_transit(1'b0, 20, "rstmid_resume");
    endtask

    task automatic test_simultaneous();
        int b_rise;
        b_rise = n_rise;
        sensor_a = 1'b1;
        sensor_b = 1'b1;
        step(30);
        vectors++;
        if (n_rise - b_rise !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_rise: got starts %0d busy %b expected 0 0", n_rise - b_rise, busy);
        end
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        step(D + 4);
        run_transit(1'b0, T, "done_on_timeout_ab");
        run_transit(1'b1, T, "done_on_timeout_ba");
        run_transit(1'b0, T + 1, "timeout_by_one");
        run_transit(1'b1, 1, "min_interval");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            step($urandom_range(0, 5));
            run_transit(1'($urandom_range(0, 1)), $urandom_range(1, T + 30), "random");
        end
    endtask

    initial begin
        test_reset();
        test_a_to_b();
        test_b_to_a();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
